// File: rtl/nes_video_pkg.sv
// Shared NES video definitions: palette geometry, FSM states and the built-in
// default palette used to initialise the palette RAM.
package nes_video_pkg;

    localparam int PAL_ENTRIES = 64;
    localparam int PAL_W       = 15;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } pal_state_t;

    // FCEUX default palette as 24-bit RRGGBB, truncated to BGR 5:5:5.
    function automatic logic [14:0] default_pal(input logic [5:0] idx);
        logic [23:0] rgb;
        case (idx)
            6'h00: rgb = 24'h747474;  6'h01: rgb = 24'h24188C;
            6'h02: rgb = 24'h0000A8;  6'h03: rgb = 24'h44009C;
            6'h04: rgb = 24'h8C0074;  6'h05: rgb = 24'hA80010;
            6'h06: rgb = 24'hA40000;  6'h07: rgb = 24'h7C0800;
            6'h08: rgb = 24'h402C00;  6'h09: rgb = 24'h004400;
            6'h0A: rgb = 24'h005000;  6'h0B: rgb = 24'h003C14;
            6'h0C: rgb = 24'h183C5C;  6'h0D: rgb = 24'h000000;
            6'h0E: rgb = 24'h000000;  6'h0F: rgb = 24'h000000;
            6'h10: rgb = 24'hBCBCBC;  6'h11: rgb = 24'h0070EC;
            6'h12: rgb = 24'h2038EC;  6'h13: rgb = 24'h8000F0;
            6'h14: rgb = 24'hBC00BC;  6'h15: rgb = 24'hE40058;
            6'h16: rgb = 24'hD82800;  6'h17: rgb = 24'hC84C0C;
            6'h18: rgb = 24'h887000;  6'h19: rgb = 24'h009400;
            6'h1A: rgb = 24'h00A800;  6'h1B: rgb = 24'h009038;
            6'h1C: rgb = 24'h008088;  6'h1D: rgb = 24'h000000;
            6'h1E: rgb = 24'h000000;  6'h1F: rgb = 24'h000000;
            6'h20: rgb = 24'hFCFCFC;  6'h21: rgb = 24'h3CBCFC;
            6'h22: rgb = 24'h5C94FC;  6'h23: rgb = 24'hCC88FC;
            6'h24: rgb = 24'hF478FC;  6'h25: rgb = 24'hFC74B4;
            6'h26: rgb = 24'hFC7460;  6'h27: rgb = 24'hFC9838;
            6'h28: rgb = 24'hF0BC3C;  6'h29: rgb = 24'h80D010;
            6'h2A: rgb = 24'h4CDC48;  6'h2B: rgb = 24'h58F898;
            6'h2C: rgb = 24'h00E8D8;  6'h2D: rgb = 24'h787878;
            6'h2E: rgb = 24'h000000;  6'h2F: rgb = 24'h000000;
            6'h30: rgb = 24'hFCFCFC;  6'h31: rgb = 24'hA8E4FC;
            6'h32: rgb = 24'hC4D4FC;  6'h33: rgb = 24'hD4C8FC;
            6'h34: rgb = 24'hFCC4FC;  6'h35: rgb = 24'hFCC4D8;
            6'h36: rgb = 24'hFCBCB0;  6'h37: rgb = 24'hFCD8A8;
            6'h38: rgb = 24'hFCE4A0;  6'h39: rgb = 24'hE0FCA0;
            6'h3A: rgb = 24'hA8F0BC;  6'h3B: rgb = 24'hB0FCCC;
            6'h3C: rgb = 24'h9CFCF0;  6'h3D: rgb = 24'hC4C4C4;
            6'h3E: rgb = 24'h000000;  6'h3F: rgb = 24'h000000;
            default: rgb = 24'h000000;
        endcase
        return {rgb[7:3], rgb[15:11], rgb[23:19]};
    endfunction

endpackage

// File: rtl/palette_ram.sv
// Single-port synchronous palette RAM with registered read data; kept free of
// reset so it maps onto block RAM.
module palette_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 15,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port and read-first registered output.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
        dout <= mem_r[addr];
    end

endmodule

// File: rtl/palette_arbiter.sv
// Shares the palette RAM port between video lookups (priority) and host writes,
// and refills the RAM with the default palette after reset or reload.
module palette_arbiter
    import nes_video_pkg::*;
#(
    parameter int ENTRIES = PAL_ENTRIES,
    parameter int PIXW    = PAL_W,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            pix_en,
    input  logic [AW-1:0]   color,
    input  logic            blank,
    input  logic            blank_only,
    input  logic            reload,
    input  logic            wr_valid,
    input  logic [AW-1:0]   wr_addr,
    input  logic [PIXW-1:0] wr_data,
    output logic            wr_ready,
    output logic [PIXW-1:0] pixel,
    output logic            pixel_valid,
    output logic            busy
);

    localparam logic [AW:0] LAST_FILL = (AW+1)'(ENTRIES - 1);

    pal_state_t      state_r;
    logic [AW:0]     fill_addr_r;
    logic            rd_pend_r;
    logic            ram_we_s;
    logic [AW-1:0]   ram_addr_s;
    logic [PIXW-1:0] ram_din_s;
    logic [PIXW-1:0] ram_dout_s;

    // Host may write only in idle video slots, never on a reload cycle.
    assign wr_ready = (state_r == RUN) && !pix_en && (!blank_only || blank) && !reload;

    // RAM port ownership: fill in INIT, otherwise video read beats host write.
    always_comb begin
        ram_we_s   = 1'b0;
        ram_addr_s = color;
        ram_din_s  = wr_data;
        case (state_r)
            INIT: begin
                ram_we_s   = 1'b1;
                ram_addr_s = fill_addr_r[AW-1:0];
                ram_din_s  = default_pal(fill_addr_r[AW-1:0]);
            end
            RUN: begin
                if (pix_en) begin
                    ram_addr_s = color;
                end else if (wr_valid && wr_ready) begin
                    ram_we_s   = 1'b1;
                    ram_addr_s = wr_addr;
                end else begin
                    ram_we_s   = 1'b0;
                end
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    palette_ram #(
        .DEPTH (ENTRIES),
        .W     (PIXW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we_s),
        .addr (ram_addr_s),
        .din  (ram_din_s),
        .dout (ram_dout_s)
    );

    // FSM, fill counter, read pipeline and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= INIT;
            fill_addr_r <= '0;
            rd_pend_r   <= 1'b0;
            pixel       <= '0;
            pixel_valid <= 1'b0;
            busy        <= 1'b1;
        end else begin
            case (state_r)
                INIT: begin
                    rd_pend_r   <= 1'b0;
                    pixel       <= '0;
                    pixel_valid <= 1'b0;
                    if (reload) begin
                        fill_addr_r <= '0;
                        busy        <= 1'b1;
                    end else if (fill_addr_r == LAST_FILL) begin
                        state_r     <= RUN;
                        fill_addr_r <= '0;
                        busy        <= 1'b0;
                    end else begin
                        fill_addr_r <= fill_addr_r + (AW+1)'(1);
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (reload) begin
                        // Flush any in-flight lookup so nothing stale appears.
                        state_r     <= INIT;
                        fill_addr_r <= '0;
                        rd_pend_r   <= 1'b0;
                        pixel       <= '0;
                        pixel_valid <= 1'b0;
                        busy        <= 1'b1;
                    end else begin
                        rd_pend_r   <= pix_en;
                        pixel_valid <= rd_pend_r;
                        busy        <= 1'b0;
                        if (rd_pend_r) begin
                            pixel <= ram_dout_s;
                        end
                    end
                end
                default: begin
                    state_r     <= INIT;
                    fill_addr_r <= '0;
                    rd_pend_r   <= 1'b0;
                    pixel       <= '0;
                    pixel_valid <= 1'b0;
                    busy        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_palette_arbiter.sv
// Directed self-checking bench for palette_arbiter.
module tb_palette_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_en;
    logic [5:0]  color;
    logic        blank;
    logic        blank_only;
    logic        reload;
    logic        wr_valid;
    logic [5:0]  wr_addr;
    logic [14:0] wr_data;
    logic        wr_ready;
    logic [14:0] pixel;
    logic        pixel_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    palette_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_en      (pix_en),
        .color       (color),
        .blank       (blank),
        .blank_only  (blank_only),
        .reload      (reload),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one lookup in cycle N and samples cycles N+1, N+2, N+3.
    task automatic do_lookup(input logic [5:0] c, output logic pv1, output logic pv2,
                             output logic [14:0] px2, output logic pv3, output logic [14:0] px3);
        pix_en = 1'b1;
        color  = c;
        tick();
        pix_en = 1'b0;
        pv1 = pixel_valid;
        tick();
        pv2 = pixel_valid;
        px2 = pixel;
        tick();
        pv3 = pixel_valid;
        px3 = pixel;
    endtask

    // Counts consecutive busy cycles starting from the current one.
    task automatic count_busy(output int cnt, output int pv_seen, output int px_nz);
        cnt = 0; pv_seen = 0; px_nz = 0;
        while (busy && cnt < 200) begin
            cnt++;
            if (pixel_valid) pv_seen++;
            if (pixel != 15'h0000) px_nz++;
            tick();
        end
    endtask

    task automatic test_reset();
        int cnt, pvs, pxn;
        reset_n = 1'b0;
        tick(); tick();
        n_checks++;
        if (busy !== 1'b1 || pixel !== 15'h0000 || pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: busy=%b pixel=%h pv=%b, required 1/0000/0", busy, pixel, pixel_valid);
        end
        reset_n = 1'b1;
        count_busy(cnt, pvs, pxn);
        n_checks++;
        if (cnt !== 64) begin
            n_fail++;
            $display("FAIL reset_busy_len: got %0d cycles, required 64", cnt);
        end
    endtask

    task automatic test_default_lookup();
        logic pv1, pv2, pv3;
        logic [14:0] px2, px3;
        logic [5:0]  cols [4] = '{6'h30, 6'h0F, 6'h00, 6'h21};
        logic [14:0] exps [4] = '{15'h7FFF, 15'h0000, 15'h39CE, 15'h7EE7};
        for (int i = 0; i < 4; i++) begin
            do_lookup(cols[i], pv1, pv2, px2, pv3, px3);
            n_checks++;
            if (pv1 !== 1'b0 || pv2 !== 1'b1 || px2 !== exps[i] || pv3 !== 1'b0 || px3 !== exps[i]) begin
                n_fail++;
                $display("FAIL default_lookup[%h]: pv=%b%b%b pixel=%h held=%h, required pv=010 pixel=%h",
                         cols[i], pv1, pv2, pv3, px2, px3, exps[i]);
            end
        end
    endtask

    task automatic test_host_write();
        logic pv1, pv2, pv3;
        logic [14:0] px2, px3;
        wr_valid = 1'b1; wr_addr = 6'h21; wr_data = 15'h1234; blank_only = 1'b0;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ready: wr_ready=%b, required 1", wr_ready);
        end
        tick();
        wr_valid = 1'b0;
        do_lookup(6'h21, pv1, pv2, px2, pv3, px3);
        n_checks++;
        if (pv1 !== 1'b0 || pv2 !== 1'b1 || px2 !== 15'h1234) begin
            n_fail++;
            $display("FAIL write_readback: pv=%b%b pixel=%h, required pv=01 pixel=1234", pv1, pv2, px2);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  cols [3] = '{6'h30, 6'h0F, 6'h21};
        logic [14:0] exps [3] = '{15'h7FFF, 15'h0000, 15'h1234};
        int bad = 0;
        for (int i = 0; i < 6; i++) begin
            pix_en = (i < 3);
            color  = (i < 3) ? cols[i] : 6'h00;
            if (i >= 2 && i < 5) begin
                if (pixel_valid !== 1'b1 || pixel !== exps[i-2]) begin
                    bad++;
                    $display("FAIL back_to_back[%0d]: pv=%b pixel=%h, required 1/%h", i, pixel_valid, pixel, exps[i-2]);
                end
            end else if (pixel_valid !== 1'b0) begin
                bad++;
                $display("FAIL back_to_back_idle[%0d]: pv=%b, required 0", i, pixel_valid);
            end
            tick();
        end
        pix_en = 1'b0;
        n_checks++;
        if (bad != 0) n_fail++;
    endtask

    task automatic test_starvation();
        logic pv1, pv2, pv3;
        logic [14:0] px2, px3;
        int leaked = 0;
        wr_valid = 1'b1; wr_addr = 6'h05; wr_data = 15'h0ABC;
        pix_en = 1'b1; color = 6'h00;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (wr_ready !== 1'b0) leaked++;
            tick();
        end
        n_checks++;
        if (leaked != 0) begin
            n_fail++;
            $display("FAIL starve_ready: wr_ready high in %0d cycles, required 0", leaked);
        end
        pix_en = 1'b0;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_accept: wr_ready=%b, required 1", wr_ready);
        end
        tick();
        wr_valid = 1'b0;
        do_lookup(6'h05, pv1, pv2, px2, pv3, px3);
        n_checks++;
        if (pv2 !== 1'b1 || px2 !== 15'h0ABC) begin
            n_fail++;
            $display("FAIL starve_readback: pv=%b pixel=%h, required 1/0abc", pv2, px2);
        end
    endtask

    task automatic test_blank_gating();
        logic pv1, pv2, pv3;
        logic [14:0] px2, px3;
        blank_only = 1'b1; blank = 1'b0;
        wr_valid = 1'b1; wr_addr = 6'h10; wr_data = 15'h2222;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_gate_closed: wr_ready=%b, required 0", wr_ready);
        end
        tick(); tick();
        blank = 1'b1;
        #1;
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL blank_gate_open: wr_ready=%b, required 1", wr_ready);
        end
        tick();
        wr_valid = 1'b0; blank = 1'b0; blank_only = 1'b0;
        do_lookup(6'h10, pv1, pv2, px2, pv3, px3);
        n_checks++;
        if (pv2 !== 1'b1 || px2 !== 15'h2222) begin
            n_fail++;
            $display("FAIL blank_readback: pv=%b pixel=%h, required 1/2222", pv2, px2);
        end
    endtask

    task automatic test_reload();
        logic pv1, pv2, pv3;
        logic [14:0] px2, px3;
        int cnt, pvs, pxn;
        wr_valid = 1'b1; wr_addr = 6'h30; wr_data = 15'h0001;
        tick();
        wr_valid = 1'b0;
        do_lookup(6'h30, pv1, pv2, px2, pv3, px3);
        n_checks++;
        if (px2 !== 15'h0001) begin
            n_fail++;
            $display("FAIL reload_pre_write: pixel=%h, required 0001", px2);
        end
        // Leave a lookup in flight when reload arrives.
        pix_en = 1'b1; color = 6'h30;
        tick();
        pix_en = 1'b0; reload = 1'b1;
        wr_valid = 1'b1; wr_addr = 6'h3F; wr_data = 15'h7777;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_ready: wr_ready=%b, required 0", wr_ready);
        end
        tick();
        reload = 1'b0; wr_valid = 1'b0;
        count_busy(cnt, pvs, pxn);
        n_checks++;
        if (cnt !== 64 || pvs !== 0 || pxn !== 0) begin
            n_fail++;
            $display("FAIL reload_fill: busy=%0d pv_seen=%0d pixel_nonzero=%0d, required 64/0/0", cnt, pvs, pxn);
        end
        do_lookup(6'h30, pv1, pv2, px2, pv3, px3);
        n_checks++;
        if (pv2 !== 1'b1 || px2 !== 15'h7FFF) begin
            n_fail++;
            $display("FAIL reload_restored: pv=%b pixel=%h, required 1/7fff", pv2, px2);
        end
    endtask

    task automatic test_reset_mid_init();
        logic pv1, pv2, pv3;
        logic [14:0] px2, px3;
        int cnt, pvs, pxn;
        do_lookup(6'h30, pv1, pv2, px2, pv3, px3);
        pix_en = 1'b1; color = 6'h30;
        tick();
        reset_n = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b1 || pixel !== 15'h0000 || pixel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL run_reset_outputs: busy=%b pixel=%h pv=%b, required 1/0000/0", busy, pixel, pixel_valid);
        end
        pix_en = 1'b0;
        reset_n = 1'b1;
        repeat (19) tick();
        wr_valid = 1'b1; wr_addr = 6'h01; wr_data = 15'h5555;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL init_ready: wr_ready=%b busy=%b, required 0/1", wr_ready, busy);
        end
        wr_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        count_busy(cnt, pvs, pxn);
        n_checks++;
        if (cnt !== 64) begin
            n_fail++;
            $display("FAIL mid_init_busy_len: got %0d cycles, required 64", cnt);
        end
        do_lookup(6'h21, pv1, pv2, px2, pv3, px3);
        n_checks++;
        if (pv2 !== 1'b1 || px2 !== 15'h7EE7) begin
            n_fail++;
            $display("FAIL mid_init_default: pv=%b pixel=%h, required 1/7ee7", pv2, px2);
        end
    endtask

    initial begin
        reset_n = 1'b0; pix_en = 1'b0; color = 6'h00; blank = 1'b0;
        blank_only = 1'b0; reload = 1'b0; wr_valid = 1'b0;
        wr_addr = 6'h00; wr_data = 15'h0000;
        test_reset();
        test_default_lookup();
        test_host_write();
        test_back_to_back();
        test_starvation();
        test_blank_gating();
        test_reload();
        test_reset_mid_init();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
